// File: rtl/reduce_wordgate_acc.sv
// Purpose : reduce each WIDTH-bit word to one bit (AND/OR/XOR/NAND) and accumulate it across a packet.
// Latency : result registered on the edge that accepts the last beat (visible the next cycle).
// Backpr. : while a result is held, in_ready follows out_ready; a beat may be accepted on the pop cycle.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   op                 - 00 AND, 01 OR, 10 XOR, 11 NAND (sampled on the first beat of a packet)
//   in_valid/in_ready  - input beat handshake; in_data word, in_last marks the final beat
//   out_valid/out_ready- result handshake; out_result, out_beats (saturating), out_overflow
module reduce_wordgate_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_overflow
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             out_result_q, out_result_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic             out_overflow_q, out_overflow_d;

    // Word reduction: NAND reduces like AND; inversion happens once at the end.
    function automatic logic reduce_word(input logic [1:0] o, input logic [WIDTH-1:0] d);
        case (o)
            OP_OR:   reduce_word = |d;
            OP_XOR:  reduce_word = ^d;
            default: reduce_word = &d;
        endcase
    endfunction

    // Cross-beat combine with the base operator (NAND accumulates as AND).
    function automatic logic combine(input logic [1:0] o, input logic a, input logic b);
        case (o)
            OP_OR:   combine = a | b;
            OP_XOR:  combine = a ^ b;
            default: combine = a & b;
        endcase
    endfunction

    logic             beat_acc;
    logic             start_pkt;
    logic [1:0]       beat_op;
    logic             red_bit;
    logic             acc_next;
    logic             res_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // Ready is a pure decode of state and out_ready, forced low during reset.
    assign in_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_ACC) ||
                               ((state_q == ST_HOLD) && out_ready));

    assign beat_acc  = in_valid && in_ready;
    // Any accepted beat outside ACC opens a new packet (IDLE, or HOLD on the pop cycle).
    assign start_pkt = beat_acc && (state_q != ST_ACC);
    assign beat_op   = start_pkt ? op : op_q;
    assign red_bit   = reduce_word(beat_op, in_data);
    assign acc_next  = start_pkt ? red_bit : combine(op_q, acc_q, red_bit);
    assign res_next  = (beat_op == OP_NAND) ? ~acc_next : acc_next;
    assign cnt_next  = start_pkt ? CNT_ONE :
                       ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);
    assign ovf_next  = start_pkt ? 1'b0 : (ovf_q || (cnt_q == CNT_MAX));

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid_q;
        out_result_d   = out_result_q;
        out_beats_d    = out_beats_q;
        out_overflow_d = out_overflow_q;

        if (beat_acc) begin
            op_d  = beat_op;
            acc_d = acc_next;
            cnt_d = cnt_next;
            ovf_d = ovf_next;
            if (in_last) begin
                state_d        = ST_HOLD;
                out_valid_d    = 1'b1;
                out_result_d   = res_next;
                out_beats_d    = cnt_next;
                out_overflow_d = ovf_next;
            end else begin
                state_d     = ST_ACC;
                out_valid_d = 1'b0;
            end
        end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_AND;
            acc_q          <= 1'b0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_result_q   <= 1'b0;
            out_beats_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_beats_q    <= out_beats_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_beats    = out_beats_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_reduce_wordgate_acc.sv
module tb_reduce_wordgate_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] op = 2'b00;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, out_result, out_overflow;
    logic [3:0] out_beats;
    logic       in_ready2, out_valid2, out_result2, out_overflow2;
    logic [1:0] out_beats2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       res;
        logic [3:0] b4;
        logic       o4;
        logic [1:0] b2;
        logic       o2;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    reduce_wordgate_acc #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_beats(out_beats), .out_overflow(out_overflow)
    );

    // Same stimulus into a 2-bit counter variant to reach saturation quickly.
    reduce_wordgate_acc #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_beats(out_beats2), .out_overflow(out_overflow2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected result is hand-computed by the caller; beat counts follow from the length.
    task automatic push_exp(input logic res, input int n);
        exp_t e;
        e.res = res;
        e.b4  = (n > 15) ? 4'd15 : 4'(n);
        e.o4  = (n > 15);
        e.b2  = (n > 3) ? 2'd3 : 2'(n);
        e.o2  = (n > 3);
        exp_q.push_back(e);
    endtask

    // Present one beat and hold it until accepted (ready sampled mid-cycle).
    task automatic send_beat(input logic [1:0] o, input logic [7:0] d, input logic l);
        logic rdy;
        int   guard;
        op = o; in_data = d; in_last = l; in_valid = 1'b1;
        guard = 0;
        rdy = 1'b0;
        while (!rdy) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!rdy && guard > 200) begin
                errors++;
                $display("FAIL beat_accept_timeout: in_ready stuck at 0, expected 1");
                rdy = 1'b1;
            end
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = 8'hxx;
        in_last  = 1'bx;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops an expectation on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: result=%0b beats=%0d with empty scoreboard",
                         out_result, out_beats);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", {31'd0, out_result}, {31'd0, e.res});
                check("beats_w4", {28'd0, out_beats}, {28'd0, e.b4});
                check("overflow_w4", {31'd0, out_overflow}, {31'd0, e.o4});
                check("valid_w2", {31'd0, out_valid2}, 32'd1);
                check("result_w2", {31'd0, out_result2}, {31'd0, e.res});
                check("beats_w2", {30'd0, out_beats2}, {30'd0, e.b2});
                check("overflow_w2", {31'd0, out_overflow2}, {31'd0, e.o2});
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_beats", {28'd0, out_beats}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 1);

        // 1: AND single 0xFF
        push_exp(1'b1, 1); send_beat(2'b00, 8'hFF, 1'b1); idle_in();
        // 2: AND 3 beats -> 0 ; OR 3 beats -> 1
        send_beat(2'b00, 8'hFF, 1'b0); send_beat(2'b00, 8'hFE, 1'b0);
        push_exp(1'b0, 3); send_beat(2'b00, 8'hFF, 1'b1);
        send_beat(2'b01, 8'h00, 1'b0); send_beat(2'b01, 8'h00, 1'b0);
        push_exp(1'b1, 3); send_beat(2'b01, 8'h10, 1'b1); idle_in();
        // 3: XOR 01,03 -> 1 ; NAND FF -> 0 ; NAND FF,0F -> 1 ; AND then op=OR mid-packet -> 0
        send_beat(2'b10, 8'h01, 1'b0);
        push_exp(1'b1, 2); send_beat(2'b10, 8'h03, 1'b1);
        push_exp(1'b0, 1); send_beat(2'b11, 8'hFF, 1'b1);
        send_beat(2'b11, 8'hFF, 1'b0);
        push_exp(1'b1, 2); send_beat(2'b11, 8'h0F, 1'b1);
        send_beat(2'b00, 8'hFF, 1'b0); send_beat(2'b01, 8'h00, 1'b0);
        push_exp(1'b0, 3); send_beat(2'b01, 8'hFF, 1'b1); idle_in();
        drain();

        // 4: backpressure, then pop and accept a new beat in the same cycle
        out_ready = 1'b0;
        push_exp(1'b0, 1); send_beat(2'b00, 8'hAA, 1'b1); idle_in();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, out_valid}, 1);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            check("bp_result", {31'd0, out_result}, 0);
            check("bp_beats", {28'd0, out_beats}, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push_exp(1'b1, 1); send_beat(2'b01, 8'h0F, 1'b1); idle_in();
        check("pop_accept_valid", {31'd0, out_valid}, 1);
        check("pop_accept_result", {31'd0, out_result}, 1);
        drain();

        // 5: saturation. 5 x FF (w2 saturates), 15 beats OR (w4 at max, no overflow), 16 beats AND
        for (int i = 0; i < 4; i++) send_beat(2'b00, 8'hFF, 1'b0);
        push_exp(1'b1, 5); send_beat(2'b00, 8'hFF, 1'b1);
        for (int i = 0; i < 14; i++) send_beat(2'b01, (i == 7) ? 8'h01 : 8'h00, 1'b0);
        push_exp(1'b1, 15); send_beat(2'b01, 8'h00, 1'b1);
        for (int i = 0; i < 15; i++) send_beat(2'b00, 8'hFF, 1'b0);
        push_exp(1'b1, 16); send_beat(2'b00, 8'hFF, 1'b1); idle_in();
        drain();
        check("after_pop_valid", {31'd0, out_valid}, 0);

        // 6: reset mid-packet discards the partial AND packet of zeros
        send_beat(2'b00, 8'h00, 1'b0); send_beat(2'b00, 8'h00, 1'b0); idle_in();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_out_result", {31'd0, out_result}, 0);
        check("midrst_out_beats", {28'd0, out_beats}, 0);
        check("midrst_out_overflow", {31'd0, out_overflow}, 0);
        check("midrst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1 rst = 1'b0;
        push_exp(1'b1, 1); send_beat(2'b00, 8'hFF, 1'b1); idle_in();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
